// File: rtl/dsm_pkg.sv
// Shared constants and state encoding for the digital signal measurement block.
package dsm_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_LOW,
    WAIT_RISE,
    HIGH,
    LOW,
    DONE
  } dsm_state_e;

endpackage

// File: rtl/dsm_channel.sv
// One measurement channel: pin synchronizer, period FSM, saturating counter, result registers.
module dsm_channel
  import dsm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pin,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync_meta;
  logic             sync;
  logic             prev;
  logic             start_d;
  logic             rise;
  logic             fall;
  logic             start_edge;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  dsm_state_e       state;

  assign rise       = sync & ~prev;
  assign fall       = ~sync & prev;
  assign start_edge = start & ~start_d;
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // Two-flop pin synchronizer, history flop for edge detection, start edge register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      prev      <= 1'b0;
      start_d   <= 1'b0;
    end else begin
      sync_meta <= pin;
      sync      <= sync_meta;
      prev      <= sync;
      start_d   <= start;
    end
  end

  // Period measurement FSM; a dropped start aborts any in-flight measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      high_time <= '0;
      low_time  <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            done  <= 1'b0;
            state <= ARM;
          end
        end
        ARM: begin
          if (!start)    state <= IDLE;
          else if (sync) state <= WAIT_LOW;
          else           state <= WAIT_RISE;
        end
        WAIT_LOW: begin
          if (!start)     state <= IDLE;
          else if (!sync) state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (!start) begin
            state <= IDLE;
          end else if (rise) begin
            cnt   <= CNT_W'(1);
            state <= HIGH;
          end
        end
        HIGH: begin
          if (!start) begin
            state <= IDLE;
          end else if (fall) begin
            high_time <= cnt;
            cnt       <= CNT_W'(1);
            state     <= LOW;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LOW: begin
          if (!start) begin
            state <= IDLE;
          end else if (rise) begin
            low_time <= cnt;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          if (start_edge) begin
            done  <= 1'b0;
            state <= ARM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dsm_multi_channel.sv
// Array of independent period-measurement channels with packed result buses.
module dsm_multi_channel
  import dsm_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHANNELS-1:0]       measure_start,
  input  logic [NUM_CHANNELS-1:0]       measure_pin,
  output logic [NUM_CHANNELS*CNT_W-1:0] high_time,
  output logic [NUM_CHANNELS*CNT_W-1:0] low_time,
  output logic [NUM_CHANNELS-1:0]       measure_done
);

  // One channel instance per pin; channel i drives slice i of each result bus.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    dsm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .start    (measure_start[i]),
      .pin      (measure_pin[i]),
      .high_time(high_time[i*CNT_W +: CNT_W]),
      .low_time (low_time[i*CNT_W +: CNT_W]),
      .done     (measure_done[i])
    );
  end

endmodule

// File: tb/tb_dsm_multi_channel.sv
// Bench for dsm_multi_channel: waveform generators, edge-timestamp model, per-cycle compare.
module tb_dsm_multi_channel;

  localparam int NCH  = 8;
  localparam int CW   = 16;
  localparam int MAXC = 65535;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    measure_start;
  logic [NCH-1:0]    measure_pin;
  logic [NCH*CW-1:0] high_time;
  logic [NCH*CW-1:0] low_time;
  logic [NCH-1:0]    measure_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  dsm_multi_channel #(.NUM_CHANNELS(NCH), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .measure_start(measure_start),
    .measure_pin  (measure_pin),
    .high_time    (high_time),
    .low_time     (low_time),
    .measure_done (measure_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pin waveform generators: H high samples then L low samples, repeating.
  int gen_h[NCH], gen_l[NCH], gen_cnt[NCH];
  bit gen_en[NCH], gen_ph[NCH], idle_lvl[NCH];

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!gen_en[i]) begin
        measure_pin[i] = idle_lvl[i];
        gen_cnt[i] = 0;
        gen_ph[i] = 1'b1;
      end else begin
        measure_pin[i] = gen_ph[i];
        gen_cnt[i]++;
        if (gen_cnt[i] >= (gen_ph[i] ? gen_h[i] : gen_l[i])) begin
          gen_cnt[i] = 0;
          gen_ph[i] = ~gen_ph[i];
        end
      end
    end
  end

  // Model: timestamps of the first rise, fall and next rise after arming.
  bit m_prev_pin[NCH], m_prev_st[NCH], m_armed[NCH], m_done[NCH];
  int m_n[NCH], m_t1[NCH], m_t2[NCH], m_done_cyc[NCH];
  int exp_h[NCH], exp_l[NCH];

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_prev_pin[i] = 1'b0; m_prev_st[i] = 1'b0;
        m_armed[i] = 1'b0; m_done[i] = 1'b0; m_n[i] = 0;
        exp_h[i] = 0; exp_l[i] = 0;
      end else begin
        bit r, f;
        r = measure_pin[i] & ~m_prev_pin[i];
        f = ~measure_pin[i] & m_prev_pin[i];
        if (measure_start[i] && !m_prev_st[i]) begin
          m_armed[i] = 1'b1; m_done[i] = 1'b0; m_n[i] = 0;
        end else if (!measure_start[i] && m_armed[i] && !m_done[i]) begin
          m_armed[i] = 1'b0;
        end
        if (m_armed[i] && !m_done[i]) begin
          if (r && m_n[i] == 0) begin
            m_t1[i] = cyc; m_n[i] = 1;
          end else if (f && m_n[i] == 1) begin
            exp_h[i] = sat(cyc - m_t1[i]); m_t2[i] = cyc; m_n[i] = 2;
          end else if (r && m_n[i] == 2) begin
            exp_l[i] = sat(cyc - m_t2[i]); m_done[i] = 1'b1; m_done_cyc[i] = cyc;
          end
        end
        m_prev_pin[i] = measure_pin[i];
        m_prev_st[i] = measure_start[i];
      end
    end
  end

  function automatic int hi(input int ch);
    return int'(high_time[ch*CW +: CW]);
  endfunction

  function automatic int lo(input int ch);
    return int'(low_time[ch*CW +: CW]);
  endfunction

  // Per-cycle compare: a raised done must carry the model's pair; a model result must surface.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        if (measure_done[i]) begin
          checks++;
          if (!m_done[i] || hi(i) != exp_h[i] || lo(i) != exp_l[i]) begin
            errors++;
            $display("FAIL cmp_done ch%0d: got done=1 high=%0d low=%0d, need model_done=%0d high=%0d low=%0d",
                     i, hi(i), lo(i), m_done[i], exp_h[i], exp_l[i]);
          end
        end
        if (m_done[i] && (cyc - m_done_cyc[i]) > 4) begin
          checks++;
          if (!measure_done[i]) begin
            errors++;
            $display("FAIL cmp_latency ch%0d: done=0 %0d cycles after final rise, need 1",
                     i, cyc - m_done_cyc[i]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input logic [NCH-1:0] mask, input int budget, input string name);
    int k;
    k = 0;
    while (((measure_done & mask) != mask) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if ((measure_done & mask) != mask) begin
      errors++;
      $display("FAIL %s: timeout, done=%h, need mask %h", name, measure_done, mask);
    end
  endtask

  task automatic start_gen(input int ch, input int h, input int l);
    gen_h[ch] = h;
    gen_l[ch] = l;
    gen_en[ch] = 1'b1;
  endtask

  int seq_h[NCH] = '{50, 25, 75, 10, 90, 40, 60, 80};
  int par_h[NCH] = '{100, 110, 120, 130, 140, 150, 160, 180};

  initial begin
    rst = 1'b1;
    measure_start = '0;
    for (int i = 0; i < NCH; i++) begin
      gen_en[i] = 1'b0; idle_lvl[i] = 1'b0; gen_h[i] = 1; gen_l[i] = 1;
    end

    // Reset state
    cycles(10);
    chk("reset_done", int'(measure_done), 0);
    chk("reset_high", int'(high_time == '0), 1);
    chk("reset_low", int'(low_time == '0), 1);
    rst = 1'b0;
    cycles(3);

    // Channels one at a time, pin low when armed
    for (int i = 0; i < NCH; i++) begin
      measure_start[i] = 1'b1;
      cycles(5);
      start_gen(i, seq_h[i], 100 - seq_h[i]);
      wait_done(NCH'(1) << i, 400, $sformatf("seq_wait ch%0d", i));
      cycles(105);
      gen_en[i] = 1'b0;
      cycles(3);
      chk($sformatf("seq_high ch%0d", i), hi(i), seq_h[i]);
      chk($sformatf("seq_low ch%0d", i), lo(i), 100 - seq_h[i]);
      chk($sformatf("seq_model_h ch%0d", i), exp_h[i], seq_h[i]);
    end
    measure_start = '0;
    cycles(5);
    chk("held_done", int'(measure_done), 8'hff);
    chk("held_high ch3", hi(3), 10);
    chk("held_low ch4", lo(4), 10);

    // Pin already high when start rises: the partial high is ignored
    idle_lvl[0] = 1'b1;
    cycles(5);
    measure_start[0] = 1'b1;
    cycles(10);
    start_gen(0, 30, 20);
    wait_done(NCH'(1), 300, "prehigh_wait");
    chk("prehigh_high", hi(0), 30);
    chk("prehigh_low", lo(0), 20);
    gen_en[0] = 1'b0;
    idle_lvl[0] = 1'b0;
    measure_start[0] = 1'b0;
    cycles(5);

    // All channels started together
    measure_start = '1;
    cycles(5);
    for (int i = 0; i < NCH; i++) start_gen(i, par_h[i], 200 - par_h[i]);
    wait_done('1, 800, "par_wait");
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("par_high ch%0d", i), hi(i), par_h[i]);
      chk($sformatf("par_low ch%0d", i), lo(i), 200 - par_h[i]);
    end
    for (int i = 0; i < NCH; i++) gen_en[i] = 1'b0;
    cycles(5);

    // Abort in HIGH keeps previous results
    measure_start[1] = 1'b0;
    cycles(3);
    measure_start[1] = 1'b1;
    cycles(5);
    start_gen(1, 50, 50);
    cycles(20);
    measure_start[1] = 1'b0;
    cycles(5);
    chk("abort_done", int'(measure_done[1]), 0);
    chk("abort_high", hi(1), 110);
    chk("abort_low", lo(1), 90);
    gen_en[1] = 1'b0;
    cycles(3);

    // Reset during LOW
    measure_start[2] = 1'b0;
    cycles(3);
    measure_start[2] = 1'b1;
    cycles(5);
    start_gen(2, 40, 40);
    cycles(60);
    rst = 1'b1;
    measure_start = '0;
    cycles(2);
    chk("rst_low_done", int'(measure_done), 0);
    chk("rst_low_high", int'(high_time == '0), 1);
    chk("rst_low_low", int'(low_time == '0), 1);
    gen_en[2] = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(5);
    chk("post_rst_done", int'(measure_done), 0);

    // Saturation of a long high phase
    measure_start[3] = 1'b1;
    cycles(5);
    start_gen(3, 70000, 5);
    wait_done(NCH'(8), 71000, "sat_wait");
    chk("sat_high", hi(3), MAXC);
    chk("sat_low", lo(3), 5);
    chk("sat_model_h", exp_h[3], MAXC);
    chk("sat_done", int'(measure_done[3]), 1);
    gen_en[3] = 1'b0;
    cycles(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
